// File: rtl/mips_pipeline_core.sv
// mips_pipeline_core: five-stage MIPS integer core with E-stage forwarding, load/branch stalls and D-stage branch resolution
module mips_pipeline_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstF,
    input  logic [31:0] ReadDataM,
    output logic [31:0] PCF,
    output logic        MemWriteM,
    output logic        MemReadM,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } fd_t;
    typedef struct packed {
        logic        rw;
        logic        ld;
        logic        st;
        logic        isrc;
        logic [2:0]  alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } de_t;
    typedef struct packed {
        logic        rw;
        logic        ld;
        logic        st;
        logic [4:0]  wr;
        logic [31:0] y;
        logic [31:0] wd;
    } em_t;
    typedef struct packed {
        logic        rw;
        logic        ld;
        logic [4:0]  wr;
        logic [31:0] y;
        logic [31:0] rdata;
    } mw_t;

    logic [31:0] pc_q, pc_d;
    fd_t         fd_q, fd_d;
    de_t         de_q, de_d;
    em_t         em_q, em_d;
    mw_t         mw_q, mw_d;
    logic [31:0] rf_q [32];

    logic [5:0]  op_d, fn_d;
    logic [4:0]  rs_d, rt_d, rd_d;
    logic [31:0] imm_d, res_w, rd1_d, rd2_d, ca_d, cb_d;
    logic        r_d, lw_d, sw_d, beq_d, addi_d, j_d;
    logic        lw_stall, br_stall, stall, take_d;
    logic [31:0] fa_e, fb_e, sb_e, y_e;

    assign op_d  = fd_q.instr[31:26];
    assign fn_d  = fd_q.instr[5:0];
    assign rs_d  = fd_q.instr[25:21];
    assign rt_d  = fd_q.instr[20:16];
    assign rd_d  = fd_q.instr[15:11];
    assign imm_d = {{16{fd_q.instr[15]}}, fd_q.instr[15:0]};

    assign r_d    = (op_d == 6'h00) && (fn_d == 6'h20 || fn_d == 6'h22 || fn_d == 6'h24 ||
                                        fn_d == 6'h25 || fn_d == 6'h2a);
    assign lw_d   = op_d == 6'h23;
    assign sw_d   = op_d == 6'h2b;
    assign beq_d  = op_d == 6'h04;
    assign addi_d = op_d == 6'h08;
    assign j_d    = op_d == 6'h02;

    // W result bypasses the register file so D sees a same-cycle write
    assign res_w = mw_q.ld ? mw_q.rdata : mw_q.y;
    assign rd1_d = rs_d == 5'd0 ? 32'd0 : (mw_q.rw && mw_q.wr == rs_d) ? res_w : rf_q[rs_d];
    assign rd2_d = rt_d == 5'd0 ? 32'd0 : (mw_q.rw && mw_q.wr == rt_d) ? res_w : rf_q[rt_d];
    assign ca_d  = (rs_d != 5'd0 && em_q.rw && em_q.wr == rs_d) ? em_q.y : rd1_d;
    assign cb_d  = (rt_d != 5'd0 && em_q.rw && em_q.wr == rt_d) ? em_q.y : rd2_d;

    assign lw_stall = de_q.ld && (de_q.wr == rs_d || de_q.wr == rt_d);
    assign br_stall = beq_d && ((de_q.rw && (de_q.wr == rs_d || de_q.wr == rt_d)) ||
                                (em_q.ld && (em_q.wr == rs_d || em_q.wr == rt_d)));
    assign stall    = lw_stall || br_stall;
    assign take_d   = beq_d && (ca_d == cb_d);

    assign pc_d = stall  ? pc_q :
                  take_d ? fd_q.pcp4 + {imm_d[29:0], 2'b00} :
                  j_d    ? {fd_q.pcp4[31:28], fd_q.instr[25:0], 2'b00} :
                           pc_q + 32'd4;
    assign fd_d = stall ? fd_q : (take_d || j_d) ? '0 : fd_t'({InstF, pc_q + 32'd4});

    always_comb begin
        de_d      = '0;
        de_d.rw   = r_d || lw_d || addi_d;
        de_d.ld   = lw_d;
        de_d.st   = sw_d;
        de_d.isrc = lw_d || sw_d || addi_d;
        de_d.alu  = !r_d ? 3'd0 : fn_d == 6'h22 ? 3'd1 : fn_d == 6'h24 ? 3'd2 :
                    fn_d == 6'h25 ? 3'd3 : fn_d == 6'h2a ? 3'd4 : 3'd0;
        de_d.rs   = rs_d;
        de_d.rt   = rt_d;
        de_d.wr   = r_d ? rd_d : rt_d;
        de_d.a    = rd1_d;
        de_d.b    = rd2_d;
        de_d.imm  = imm_d;
        if (stall) de_d = '0;
    end

    assign fa_e = (de_q.rs != 5'd0 && em_q.rw && em_q.wr == de_q.rs) ? em_q.y :
                  (de_q.rs != 5'd0 && mw_q.rw && mw_q.wr == de_q.rs) ? res_w : de_q.a;
    assign fb_e = (de_q.rt != 5'd0 && em_q.rw && em_q.wr == de_q.rt) ? em_q.y :
                  (de_q.rt != 5'd0 && mw_q.rw && mw_q.wr == de_q.rt) ? res_w : de_q.b;
    assign sb_e = de_q.isrc ? de_q.imm : fb_e;
    assign y_e  = de_q.alu == 3'd1 ? fa_e - sb_e :
                  de_q.alu == 3'd2 ? fa_e & sb_e :
                  de_q.alu == 3'd3 ? fa_e | sb_e :
                  de_q.alu == 3'd4 ? {31'd0, $signed(fa_e) < $signed(sb_e)} :
                                     fa_e + sb_e;

    assign em_d = {de_q.rw, de_q.ld, de_q.st, de_q.wr, y_e, fb_e};
    assign mw_d = {em_q.rw, em_q.ld, em_q.wr, em_q.y, ReadDataM};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            fd_q <= '0;
            de_q <= '0;
            em_q <= '0;
            mw_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            fd_q <= fd_d;
            de_q <= de_d;
            em_q <= em_d;
            mw_q <= mw_d;
            if (mw_q.rw && mw_q.wr != 5'd0) rf_q[mw_q.wr] <= res_w;
        end
    end

    assign PCF        = pc_q;
    assign MemWriteM  = em_q.st;
    assign MemReadM   = em_q.ld;
    assign ALUResultM = em_q.y;
    assign WriteDataM = em_q.wd;
endmodule

// File: tb/tb_mips_pipeline_core.sv
// tb_mips_pipeline_core: directed programs with a store scoreboard (address, data, cycle after reset release)
module tb_mips_pipeline_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] InstF, ReadDataM, PCF, ALUResultM, WriteDataM;
    logic        MemWriteM, MemReadM;

    mips_pipeline_core dut (
        .clk(clk), .rst(rst), .InstF(InstF), .ReadDataM(ReadDataM), .PCF(PCF),
        .MemWriteM(MemWriteM), .MemReadM(MemReadM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    always @(negedge clk) begin
        InstF     <= imem[PCF[7:2]];
        ReadDataM <= dmem[ALUResultM[7:2]];
        if (MemWriteM === 1'b1) dmem[ALUResultM[7:2]] <= WriteDataM;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } st_t;
    st_t sb[$];
    int  n_cmp = 0;
    int  n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ei(input int op, input int s, input int t, input int imm);
        return {op[5:0], s[4:0], t[4:0], imm[15:0]};
    endfunction
    function automatic logic [31:0] er(input int s, input int t, input int d, input int fn);
        return {6'd0, s[4:0], t[4:0], d[4:0], 5'd0, fn[5:0]};
    endfunction
    function automatic logic [31:0] ej(input int idx);
        return {6'h02, idx[25:0]};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic exp_st(input logic [31:0] a, input logic [31:0] d, input int c);
        sb.push_back('{a, d, c});
    endtask

    task automatic start();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_memwrite", {31'd0, MemWriteM}, 32'h0);
        chk("rst_memread", {31'd0, MemReadM}, 32'h0);
        chk("rst_aluresult", ALUResultM, 32'h0);
        chk("rst_writedata", WriteDataM, 32'h0);
        rst = 1'b0;
    endtask

    // cycle n is the n-th cycle after reset release; PCF is 0 in cycle 0
    task automatic run(input int ncyc, input int npc);
        st_t e;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (n < npc) chk("pcf_seq", PCF, 32'(4 * n));
            if (MemWriteM === 1'b1) begin
                if (sb.size() == 0) chk("unexpected_store_addr", ALUResultM, 32'hffff_ffff);
                else begin
                    e = sb.pop_front();
                    chk("store_addr", ALUResultM, e.a);
                    chk("store_data", WriteDataM, e.d);
                    if (e.c >= 0) chk("store_cycle", 32'(n), 32'(e.c));
                end
            end
        end
        chk("stores_missing", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    initial begin
        // standard program
        clear_prog();
        imem[0]  = ei(8, 0, 2, 5);
        imem[1]  = ei(8, 0, 3, 12);
        imem[2]  = ei(8, 3, 7, -9);
        imem[3]  = er(7, 2, 4, 'h25);
        imem[4]  = er(3, 4, 5, 'h24);
        imem[5]  = er(5, 4, 5, 'h20);
        imem[6]  = ei(4, 5, 7, 10);
        imem[7]  = er(3, 4, 4, 'h2a);
        imem[8]  = ei(4, 4, 0, 1);
        imem[9]  = ei(8, 0, 5, 0);
        imem[10] = er(7, 2, 4, 'h2a);
        imem[11] = er(4, 5, 7, 'h20);
        imem[12] = er(7, 2, 7, 'h22);
        imem[13] = ei('h2b, 3, 7, 68);
        imem[14] = ei('h23, 0, 2, 80);
        imem[15] = ej(17);
        imem[16] = ei(8, 0, 2, 1);
        imem[17] = ei('h2b, 0, 2, 84);
        start();
        exp_st(32'd80, 32'd7, -1);
        exp_st(32'd84, 32'd7, -1);
        run(60, 4);

        // back-to-back dependencies, no stalls
        clear_prog();
        imem[0] = ei(8, 0, 1, 3);
        imem[1] = er(1, 1, 2, 'h20);
        imem[2] = er(2, 1, 3, 'h22);
        imem[3] = ei('h2b, 0, 2, 0);
        imem[4] = ei('h2b, 0, 3, 4);
        start();
        exp_st(32'd0, 32'd6, 6);
        exp_st(32'd4, 32'd3, 7);
        run(16, 4);

        // load-use: exactly one stall cycle
        clear_prog();
        imem[0] = ei(8, 0, 6, 7);
        imem[1] = ei('h2b, 0, 6, 80);
        imem[2] = ei('h23, 0, 4, 80);
        imem[3] = er(4, 4, 5, 'h20);
        imem[4] = ei('h2b, 0, 5, 0);
        start();
        exp_st(32'd80, 32'd7, 4);
        exp_st(32'd0, 32'd14, 8);
        run(16, 4);

        // taken beq on a just-computed operand: 1 stall + 1 flush, wrong path leaves $3 untouched
        clear_prog();
        imem[0] = ei(8, 0, 2, 2);
        imem[1] = ei(8, 0, 1, 2);
        imem[2] = ei(4, 1, 2, 2);
        imem[3] = ei(8, 0, 3, 9);
        imem[4] = ei('h2b, 0, 1, 8);
        imem[5] = ei('h2b, 0, 3, 12);
        imem[6] = ei('h2b, 0, 1, 16);
        start();
        exp_st(32'd12, 32'd0, 8);
        exp_st(32'd16, 32'd2, 9);
        run(16, 3);

        // reset while sw is in E
        clear_prog();
        imem[0] = ei(8, 0, 1, 5);
        imem[1] = ei('h2b, 0, 1, 0);
        start();
        run(3, 3);
        @(negedge clk);
        chk("sw_in_e_memwrite", {31'd0, MemWriteM}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_memwrite", {31'd0, MemWriteM}, 32'h0);
        chk("midrst_pcf", PCF, 32'h0);
        start();
        exp_st(32'd0, 32'd5, 4);
        run(12, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
